// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, opcode bounds, defaults.
package imem_loader_pkg;

    localparam int unsigned DefDepth = 16;
    localparam int unsigned DefAw    = 4;

    localparam int unsigned OpMsb      = 15;
    localparam int unsigned OpLsb      = 12;
    localparam logic [3:0]  OpMaxLegal = 4'd6;

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StLow,
        StWrite,
        StDone
    } state_e;

    function automatic logic is_illegal(input logic [15:0] word);
        return word[OpMsb:OpLsb] > OpMaxLegal;
    endfunction

endpackage

// File: rtl/imem_1w1r.sv
// Instruction memory: one synchronous write port, one registered read port (read-before-write).
module imem_1w1r
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];

    // Array is deliberately left out of reset so contents survive a mid-session rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes (high byte first) into the instruction memory and serves fetches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [15:0]   fetch_instr,
    output logic          loading,
    output logic          done,
    output logic [AW:0]   word_count,
    output logic [AW:0]   illegal_count
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    state_e        state_q;
    logic          ready_q;
    logic          loading_q;
    logic          done_q;
    logic [AW:0]   word_count_q;
    logic [AW:0]   illegal_count_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   stage_q;

    logic          xfer;
    logic          mem_we;
    logic [AW:0]   word_count_inc;

    assign xfer           = byte_valid && ready_q;
    assign word_count_inc = word_count_q + 1'b1;
    // rst must win over the pending write of a word caught in WRITE.
    assign mem_we         = (state_q == StWrite) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            ready_q         <= 1'b0;
            loading_q       <= 1'b0;
            done_q          <= 1'b0;
            word_count_q    <= '0;
            illegal_count_q <= '0;
            addr_q          <= '0;
            stage_q         <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q         <= StHigh;
                        ready_q         <= 1'b1;
                        loading_q       <= 1'b1;
                        done_q          <= 1'b0;
                        word_count_q    <= '0;
                        illegal_count_q <= '0;
                        addr_q          <= '0;
                    end
                end
                StHigh: begin
                    if (xfer) begin
                        stage_q[15:8] <= byte_data;
                        state_q       <= StLow;
                    end
                end
                StLow: begin
                    if (xfer) begin
                        stage_q[7:0] <= byte_data;
                        state_q      <= StWrite;
                        ready_q      <= 1'b0;
                    end
                end
                StWrite: begin
                    word_count_q <= word_count_inc;
                    addr_q       <= addr_q + 1'b1;
                    if (is_illegal(stage_q)) begin
                        illegal_count_q <= illegal_count_q + 1'b1;
                    end
                    if (word_count_inc == DepthCnt) begin
                        state_q   <= StDone;
                        loading_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q <= StHigh;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    ready_q   <= 1'b0;
                    loading_q <= 1'b0;
                end
            endcase
        end
    end

    imem_1w1r #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(addr_q),
        .wdata(stage_q),
        .raddr(fetch_addr),
        .rdata(fetch_instr)
    );

    assign byte_ready    = ready_q;
    assign loading       = loading_q;
    assign done          = done_q;
    assign word_count    = word_count_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: word-level reference memory plus a fetch scoreboard.
module tb_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] fetch_addr;
    logic [15:0]   fetch_instr;
    logic          loading;
    logic          done;
    logic [AW:0]   word_count;
    logic [AW:0]   illegal_count;

    imem_loader #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .loading      (loading),
        .done         (done),
        .word_count   (word_count),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc;
    int          exp_ic;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_q [$];
    logic        rd_issue = 1'b0;
    logic        rd_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a fetch issued before an edge is compared on the following falling edge.
    always @(posedge clk) rd_pend <= rd_issue;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check("fetch_unexpected", 32'(fetch_instr), 32'hDEAD_BEEF);
            end else begin
                check("fetch", 32'(fetch_instr), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
        byte_data  = b;
        byte_valid = 1'b1;
        rdy = 1'b0;
        for (int n = 0; n < 20 && !rdy; n++) begin
            rdy = byte_ready;
            tick();
        end
        check("byte_accept", 32'(rdy), 32'd1);
    endtask

    function automatic int rand_gap(input bit gaps);
        if (!gaps || $urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(1, 3));
    endfunction

    task automatic send_word(input logic [15:0] w, input bit gaps);
        send_byte(w[15:8], rand_gap(gaps));
        send_byte(w[7:0], rand_gap(gaps));
    endtask

    task automatic do_start();
        byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        exp_ic = 0;
    endtask

    task automatic commit(input int idx, input logic [15:0] w);
        model_mem[idx] = w;
        if (w[15:12] > 4'd6) exp_ic++;
    endtask

    task automatic fetch_all();
        byte_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = AW'(a);
            rd_issue = 1'b1;
            exp_q.push_back(model_mem[a]);
            tick();
        end
        rd_issue = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = '0;
        fetch_addr = '0;
        repeat (3) tick();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_illegal_count", 32'(illegal_count), 32'd0);
        check("rst_fetch_instr", 32'(fetch_instr), 32'd0);
        rst = 1'b0;
        tick();

        // Session 1: gap-free stream, byte_valid held high.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            w = (i == 0) ? 16'h0312 : (i == 1) ? 16'h3ABA : 16'($urandom);
            send_word(w, 1'b0);
            commit(i, w);
        end
        for (int n = 0; n < 10 && !done; n++) tick();
        byte_valid = 1'b0;
        check("load_cycles", 32'(cyc - start_cyc), 32'd48);
        check("s1_done", 32'(done), 32'd1);
        check("s1_loading", 32'(loading), 32'd0);
        check("s1_word_count", 32'(word_count), 32'd16);
        check("s1_illegal_count", 32'(illegal_count), 32'(exp_ic));
        fetch_addr = 4'd1;
        tick();
        check("s1_addr1", 32'(fetch_instr), 32'h3ABA);
        fetch_all();

        // Session 2: restart from DONE, random gaps, illegal opcodes, RBW and stray start.
        do_start();
        check("s2_done_cleared", 32'(done), 32'd0);
        check("s2_loading", 32'(loading), 32'd1);
        check("s2_word_count", 32'(word_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 8) w = 16'h7000;
            else if (i == 9) w = 16'hF123;
            else if (i == 10) w = 16'h6001;
            else w = {4'($urandom_range(0, 6)), 12'($urandom)};
            if (i == 6) begin
                send_byte(w[15:8], rand_gap(1'b1));
                byte_valid = 1'b0;
                start = 1'b1;
                tick();
                start = 1'b0;
                check("stray_start_loading", 32'(loading), 32'd1);
                check("stray_start_ready", 32'(byte_ready), 32'd1);
                check("stray_start_count", 32'(word_count), 32'd6);
                send_byte(w[7:0], rand_gap(1'b1));
            end else begin
                send_word(w, 1'b1);
            end
            if (i == 3) begin
                // Now in WRITE for word 3: same-cycle fetch sees the old word.
                byte_valid = 1'b0;
                fetch_addr = 4'd3;
                rd_issue = 1'b1;
                exp_q.push_back(model_mem[3]);
                tick();
                commit(3, w);
                exp_q.push_back(model_mem[3]);
                tick();
                rd_issue = 1'b0;
            end else begin
                commit(i, w);
            end
        end
        for (int n = 0; n < 10 && !done; n++) tick();
        byte_valid = 1'b0;
        check("s2_done", 32'(done), 32'd1);
        check("s2_word_count", 32'(word_count), 32'd16);
        check("s2_illegal_model", 32'(illegal_count), 32'(exp_ic));
        check("s2_illegal_two", 32'(illegal_count), 32'd2);
        fetch_all();

        // Session 3: reset while word 5 sits in WRITE; rst beats start and byte_valid.
        do_start();
        for (int i = 0; i < 5; i++) begin
            w = 16'($urandom);
            send_word(w, 1'b1);
            commit(i, w);
        end
        send_word(16'h5A5A ^ model_mem[5], 1'b1);
        rst = 1'b1;
        start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'hFF;
        tick();
        rst = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        check("mid_rst_loading", 32'(loading), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_illegal", 32'(illegal_count), 32'd0);
        check("mid_rst_fetch", 32'(fetch_instr), 32'd0);
        tick();
        check("mid_rst_idle", 32'(loading), 32'd0);
        fetch_all();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of 16-bit instruction words in the memory.
REQ-002 The block SHALL have parameter AW, default 4, instruction address width (log2 DEPTH).
REQ-003 The block SHALL have one clock and a synchronous active-high reset, listed first among the ports.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  pulse; begins a load session at address 0.
REQ-007 byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 byte_data  input  8  program byte; high byte of each word first.
REQ-009 byte_ready  output  1  block accepts a byte this cycle.
REQ-010 fetch_addr  input  AW  processor instruction-fetch address.
REQ-011 fetch_instr  output  16  registered instruction word read from fetch_addr.
REQ-012 loading  output  1  a load session is in progress.
REQ-013 done  output  1  sticky; DEPTH words were written.
REQ-014 word_count  output  AW+1  number of words written in the current session.
REQ-015 illegal_count  output  AW+1  number of written words with opcode field above 6.

Function
REQ-016 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both 1.
REQ-017 The FSM SHALL have states IDLE, HIGH, LOW, WRITE, DONE.
REQ-018 In IDLE, start=1 SHALL move to HIGH, clear word_count, illegal_count and done, and set the write address to 0.
REQ-019 In HIGH, a transfer SHALL latch byte_data into bits 15:8 of the staging word and move to LOW.
REQ-020 In LOW, a transfer SHALL latch byte_data into bits 7:0 and move to WRITE.
REQ-021 byte_ready SHALL be 1 only in HIGH and LOW.
REQ-022 In WRITE (one cycle), the staging word SHALL be written to memory at the write address, and word_count and the address SHALL increment.
REQ-023 In WRITE, illegal_count SHALL increment when staging word bits 15:12 exceed 6; the word SHALL still be written.
REQ-024 WRITE SHALL go to DONE when the incremented word_count equals DEPTH; otherwise it SHALL go to HIGH.
REQ-025 The write address SHALL NOT wrap: at most DEPTH words are written per session.
REQ-026 In DONE, done SHALL be 1; start=1 SHALL begin a new session exactly as from IDLE.
REQ-027 start SHALL be ignored in HIGH, LOW and WRITE.
REQ-028 loading SHALL be 1 in HIGH, LOW and WRITE, and 0 otherwise.
REQ-029 fetch_instr SHALL equal the memory word at fetch_addr sampled at the previous rising edge, giving 1-cycle latency.
REQ-030 On a same-cycle write and fetch of the same address, fetch_instr SHALL return the old word (read-before-write).
REQ-031 The minimum sustained rate SHALL be one word per 3 cycles when byte_valid is held at 1.

Reset
REQ-032 rst=1 SHALL force IDLE, byte_ready=0, loading=0, done=0, word_count=0, illegal_count=0, fetch_instr=0 and clear the staging word.
REQ-033 rst SHALL NOT alter memory contents; words written before a mid-session reset SHALL remain readable.
REQ-034 rst SHALL take priority over start and byte transfers in the same cycle.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the opcode-field bounds (bits 15:12, max legal 6) and DEPTH/AW defaults.
REQ-036 The memory SHALL be one sub-module, imem_1w1r: one synchronous write port and one registered read port, read-before-write.

Verification
REQ-037 Full load: start, stream bytes 03 12 3A BA ... (16 words) with byte_valid held at 1 -> done=1 after 48 cycles, word_count=16, fetch_addr=1 gives 16'h3ABA one cycle later.
REQ-038 Backpressure and gaps: random byte_valid gaps -> identical memory contents to the gap-free case; no byte is lost or duplicated.
REQ-039 Illegal opcodes: words 16'h7000, 16'hF123, 16'h6001 -> illegal_count=2 and all three words stored.
REQ-040 Mid-session reset: rst after word 5's low byte (in WRITE) -> IDLE, counters 0, words 0-4 intact, word 5 not written.
REQ-041 Read-before-write: fetch_addr=3 in the WRITE cycle of word 3 -> old value, new value on the next read.
REQ-042 Restart: start in DONE -> done=0 and the second stream overwrites from address 0; start during LOW is ignored.
